// File: rtl/instr_fetch_if.sv
// Signal bundle between the instruction-fetch stage, its instruction memory,
// the PC-update stage (redirects) and decode.
//
// Handshake rules: a transfer happens on a rising clock edge where the
// source's strobe (imem_req, if_valid) and the sink's acceptance (imem_gnt,
// if_ready) are both high. The source holds its strobe and payload
// (imem_addr; if_instr/if_pc) steady until that edge. The only exception is
// a redirect (pc_updated), which may retarget or withdraw them. imem_rvalid
// is a one-cycle strobe that cannot be back-pressured.
interface instr_fetch_if #(
    parameter int XLEN = 32
);
    logic            pc_updated;
    logic [XLEN-1:0] nextpc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic            busy;

    // Fetch-stage side.
    modport master (
        input  pc_updated, nextpc, imem_gnt, imem_rvalid, imem_rdata, if_ready,
        output imem_req, imem_addr, if_valid, if_instr, if_pc, busy
    );

    // Environment side: memory, PC-update stage and decode.
    modport slave (
        output pc_updated, nextpc, imem_gnt, imem_rvalid, imem_rdata, if_ready,
        input  imem_req, imem_addr, if_valid, if_instr, if_pc, busy
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction-fetch stage. It owns the architectural PC and issues one
// word-addressed read at a time to instruction memory. It buffers the
// returned words and hands {instruction, pc} to decode.
// A redirect from the PC-update stage flushes buffered words. A redirect that
// lands while a read is outstanding marks that read stale, so its data is
// dropped when it returns.
// Build option FETCH_SKID_EN: with the macro defined, the buffer is a 2-entry
// FIFO and fetch runs ahead of decode. With it undefined, the buffer is a
// single holding register and fetch follows a strict REQ->WAIT->HOLD loop.
// dbg_state exposes the FSM state: 0=IDLE, 1=REQ, 2=WAIT, 3=HOLD.
module instr_fetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;      // address of the outstanding or next request
    logic            stale;   // outstanding read was overtaken by a redirect
    logic            redirect;
    logic            push;    // returned word enters the buffer
    logic            pop;     // decode takes the head entry
    logic            room;    // buffer can accept another word after this cycle

    assign redirect = bus.pc_updated;
    assign pop      = bus.if_valid && bus.if_ready;
    // A redirect in the same cycle as rvalid drops the returning word.
    assign push     = (state == WAIT) && bus.imem_rvalid && !stale && !redirect;

`ifdef FETCH_SKID_EN
    logic [XLEN-1:0] q_instr [2];
    logic [XLEN-1:0] q_pc    [2];
    logic [1:0]      count;

    // Two-entry FIFO; entry 0 is always the head that decode sees.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_instr[0] <= '0;
            q_instr[1] <= '0;
            q_pc[0]    <= '0;
            q_pc[1]    <= '0;
            count      <= 2'd0;
        end else if (redirect) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        q_instr[0] <= bus.imem_rdata;
                        q_pc[0]    <= pc;
                    end else begin
                        q_instr[1] <= bus.imem_rdata;
                        q_pc[1]    <= pc;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    q_instr[0] <= q_instr[1];
                    q_pc[0]    <= q_pc[1];
                    count      <= count - 2'd1;
                end
                2'b11: begin
                    // A read is only issued with at most one entry held, so the
                    // head leaves and the new word becomes the head.
                    q_instr[0] <= bus.imem_rdata;
                    q_pc[0]    <= pc;
                end
                default: ;
            endcase
        end
    end

    // After a push the FIFO still has a free slot if it was empty or the head leaves.
    assign room         = (count == 2'd0) || pop;
    assign bus.if_valid = (count != 2'd0);
    assign bus.if_instr = q_instr[0];
    assign bus.if_pc    = q_pc[0];
`else
    logic [XLEN-1:0] h_instr;
    logic [XLEN-1:0] h_pc;
    logic            full;

    // Single holding register. A push only happens while it is empty, so push
    // and pop never coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_instr <= '0;
            h_pc    <= '0;
            full    <= 1'b0;
        end else if (redirect) begin
            full <= 1'b0;
        end else if (push) begin
            h_instr <= bus.imem_rdata;
            h_pc    <= pc;
            full    <= 1'b1;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

    // A returned word always fills the only slot.
    assign room         = 1'b0;
    assign bus.if_valid = full;
    assign bus.if_instr = h_instr;
    assign bus.if_pc    = h_pc;
`endif

    // Fetch sequencing: PC ownership, request issue and redirect/stale-read handling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
            stale <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect) pc <= bus.nextpc;
                    state <= REQ;
                end
                REQ: begin
                    if (redirect) begin
                        pc <= bus.nextpc;
                        // Memory took the old address anyway: wait for it and drop it.
                        if (bus.imem_gnt) begin
                            stale <= 1'b1;
                            state <= WAIT;
                        end
                    end else if (bus.imem_gnt) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.imem_rvalid) begin
                        stale <= 1'b0;
                        if (redirect) begin
                            pc    <= bus.nextpc;
                            state <= REQ;
                        end else if (stale) begin
                            state <= REQ;
                        end else begin
                            pc    <= pc + XLEN'(1);
                            state <= room ? REQ : HOLD;
                        end
                    end else if (redirect) begin
                        pc    <= bus.nextpc;
                        stale <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc    <= bus.nextpc;
                        state <= REQ;
                    end else if (pop) begin
                        state <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.imem_req  = (state == REQ);
    assign bus.imem_addr = pc;
    assign bus.busy      = (state == WAIT);
    assign dbg_state     = state;

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch. A memory responder process answers requests
// with random grant and read latency, and data is a fixed function of the
// address. A monitor keeps an expected queue of {instr, pc}. The queue holds
// the sequential program stream from RESET_PC, restarted at the redirect
// target on each redirect, and is checked on every decode handoff.
// Directed phases cover reset, in-order fetch, back-pressure, a redirect
// during an outstanding read, PC wrap, and reset with stray read data.
// A randomized phase follows.
module tb_instr_fetch;
    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    instr_fetch_if #(.XLEN(XLEN)) bus ();

    instr_fetch #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int errors   = 0;
    int handoffs = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
    endfunction

    // ---------------- memory responder ----------------
    int          mem_en  = 0;
    int          max_gnt = 0;
    int          lat_min = 0;
    int          max_lat = 0;
    int          stray_n = 0;
    bit          pend    = 1'b0;
    int          pend_wait = 0;
    logic [31:0] pend_addr = '0;
    logic [31:0] gnt_log[$];

    initial begin
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        forever begin
            @(posedge clk);
            #2;
            bus.imem_gnt    = 1'b0;
            bus.imem_rvalid = 1'b0;
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (bus.imem_req) check("one_outstanding", {95'd0, pend}, 96'd0);
                if (stray_n > 0) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = 32'hBAD0_BAD0;
                    stray_n--;
                end else if (pend) begin
                    if (pend_wait == 0) begin
                        bus.imem_rvalid = 1'b1;
                        bus.imem_rdata  = mem_word(pend_addr);
                        pend = 1'b0;
                    end else begin
                        pend_wait--;
                    end
                end
                if (bus.imem_req && !pend && mem_en != 0 &&
                    (max_gnt == 0 || $urandom_range(0, max_gnt) == 0)) begin
                    bus.imem_gnt = 1'b1;
                    pend         = 1'b1;
                    pend_addr    = bus.imem_addr;
                    pend_wait    = $urandom_range(lat_min, max_lat);
                    gnt_log.push_back(bus.imem_addr);
                end
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic [63:0] exp_q[$];
    logic [31:0] gen_pc = '0;
    bit          hold_prev = 1'b0;
    logic [63:0] hold_data = '0;
    bit          redir_prev = 1'b0;
    logic [31:0] redir_tgt = '0;

    task automatic top_up();
        while (exp_q.size() < 16) begin
            exp_q.push_back({mem_word(gen_pc), gen_pc});
            gen_pc = gen_pc + 32'd1;
        end
    endtask

    task automatic restart(input logic [31:0] start);
        exp_q.delete();
        gen_pc = start;
        top_up();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            check("rst_ctrl", {91'd0, bus.imem_req, bus.if_valid, bus.busy, dbg_state}, 96'd0);
            check("rst_addr", {64'd0, bus.imem_addr}, {64'd0, RESET_PC});
            check("rst_data", {32'd0, bus.if_instr, bus.if_pc}, 96'd0);
            restart(RESET_PC);
            hold_prev  = 1'b0;
            redir_prev = 1'b0;
        end else begin
            if (redir_prev)
                check("redirect_latency", {63'd0, bus.imem_req, bus.imem_addr}, {63'd0, 1'b1, redir_tgt});
            if (hold_prev) begin
                check("hold_valid", {95'd0, bus.if_valid}, 96'd1);
                check("hold_data", {32'd0, bus.if_instr, bus.if_pc}, {32'd0, hold_data});
            end
            if (bus.if_valid && bus.if_ready) begin
                check("handoff", {32'd0, bus.if_instr, bus.if_pc}, {32'd0, exp_q.pop_front()});
                handoffs++;
                top_up();
            end
            hold_prev = bus.if_valid && !bus.if_ready && !bus.pc_updated;
            hold_data = {bus.if_instr, bus.if_pc};
            if (bus.pc_updated) begin
                restart(bus.nextpc);
                redir_prev = !pend;
                redir_tgt  = bus.nextpc;
            end else begin
                redir_prev = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [31:0] target);
        bus.pc_updated = 1'b1;
        bus.nextpc     = target;
        tick();
        bus.pc_updated = 1'b0;
    endtask

    task automatic do_reset(input int stray);
        mem_en = 0;
        rst    = 1'b1;
        gnt_log.delete();
        repeat (3) tick();
        rst     = 1'b0;
        stray_n = stray;
        @(negedge clk);
        check("idle_after_release", {94'd0, bus.imem_req, bus.if_valid}, 96'd0);
        tick();
        @(negedge clk);
        check("first_req", {63'd0, bus.imem_req, bus.imem_addr}, {63'd0, 1'b1, RESET_PC});
    endtask

    task automatic wait_gnts(input int n, input int budget, input string name);
        int i;
        for (i = 0; i < budget && gnt_log.size() < n; i++) tick();
        if (gnt_log.size() < n) check(name, 96'(gnt_log.size()), 96'(n));
    endtask

    task automatic wait_new_gnt();
        int n;
        int i;
        n = gnt_log.size();
        for (i = 0; i < 40 && gnt_log.size() == n; i++) tick();
        if (gnt_log.size() == n) check("gnt_timeout", 96'd0, 96'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int h0;
        rst            = 1'b1;
        bus.pc_updated = 1'b0;
        bus.nextpc     = '0;
        bus.if_ready   = 1'b1;

        // Reset and in-order fetch from RESET_PC with a zero-wait memory.
        do_reset(0);
        mem_en = 1; max_gnt = 0; lat_min = 0; max_lat = 0;
        wait_gnts(4, 40, "inorder_timeout");
        for (int i = 0; i < 4 && i < gnt_log.size(); i++)
            check("inorder_addr", {64'd0, gnt_log[i]}, {64'd0, RESET_PC + 32'(i)});

        // Back-pressure: the buffer fills, then a redirect refills exactly CAP entries.
        bus.if_ready = 1'b0;
        repeat (12) tick();
        gnt_log.delete();
        redirect(32'h0000_0100);
        repeat (12) tick();
        check("capacity_gnts", 96'(gnt_log.size()), 96'(CAP));
        if (gnt_log.size() > 0) check("capacity_addr", {64'd0, gnt_log[0]}, 96'h100);
        @(negedge clk);
        check("blocked_head", {31'd0, bus.if_valid, bus.if_instr, bus.if_pc},
              {31'd0, 1'b1, mem_word(32'h100), 32'h100});
        tick();
        bus.if_ready = 1'b1;

        // Redirect while a read is outstanding: its data must be dropped.
        lat_min = 3; max_lat = 3;
        repeat (6) tick();
        wait_new_gnt();
        gnt_log.delete();
        redirect(32'h0000_0040);
        wait_gnts(1, 40, "stale_timeout");
        if (gnt_log.size() > 0) check("after_stale_addr", {64'd0, gnt_log[0]}, 96'h40);
        lat_min = 0; max_lat = 0;
        repeat (10) tick();

        // PC wrap from the top of the address space.
        mem_en = 0;
        repeat (6) tick();
        gnt_log.delete();
        redirect(32'hFFFF_FFFF);
        mem_en = 1;
        wait_gnts(2, 40, "wrap_timeout");
        if (gnt_log.size() > 1) begin
            check("wrap_addr0", {64'd0, gnt_log[0]}, {64'd0, 32'hFFFF_FFFF});
            check("wrap_addr1", {64'd0, gnt_log[1]}, 96'd0);
        end
        repeat (6) tick();

        // Reset in the middle of a read, then stray rvalids after release.
        lat_min = 3; max_lat = 3;
        wait_new_gnt();
        tick();
        do_reset(2);
        mem_en = 1; lat_min = 0; max_lat = 0;
        wait_gnts(2, 40, "restart_timeout");
        if (gnt_log.size() > 1) begin
            check("restart_addr0", {64'd0, gnt_log[0]}, {64'd0, RESET_PC});
            check("restart_addr1", {64'd0, gnt_log[1]}, {64'd0, RESET_PC + 32'd1});
        end

        // Randomized traffic: latencies, back-pressure and redirects.
        h0 = handoffs;
        for (int c = 0; c < 800; c++) begin
            if (c % 100 == 0) begin
                max_gnt = $urandom_range(0, 2);
                lat_min = 0;
                max_lat = $urandom_range(0, 2);
            end
            bus.if_ready = ($urandom_range(0, 3) != 0);
            if (!bus.pc_updated && $urandom_range(0, 24) == 0) begin
                bus.pc_updated = 1'b1;
                bus.nextpc     = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom();
            end else begin
                bus.pc_updated = 1'b0;
            end
            tick();
        end
        bus.pc_updated = 1'b0;
        check("random_progress", {95'd0, (handoffs - h0) > 50}, 96'd1);

        // Drain: the stage must keep delivering once pressure is removed.
        bus.if_ready = 1'b1; max_gnt = 0; max_lat = 0;
        h0 = handoffs;
        for (int i = 0; i < 40 && handoffs < h0 + 4; i++) tick();
        check("drain_progress", {95'd0, handoffs >= h0 + 4}, 96'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

endmodule
